// File: rtl/hrm_io_pkg.sv
// hrm_io_pkg: shared constants and helpers for the CPU I/O blocks.
//   - serializer state encodings (IDLE/START/DATA/STOP)
//   - clks_per_bit(): serial bit period in system clocks
//   - clog2(): ceiling log2 for sizing pointers and counters
package hrm_io_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  // Returns 0 for v <= 1, so callers that need at least one bit must
  // guarantee v >= 2.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/outbox_uart_tx_if.sv
// outbox_uart_tx_if: OUTBOX write handshake between the control unit and the
// output FIFO.
//   wO      : one-cycle write strobe (master -> slave)
//   i_data  : byte written, valid while wO=1 (master -> slave)
//   outFull : FIFO full; the master must hold off writing (slave -> master)
//
// Handshake: a byte transfers on a rising edge where wO=1 and outFull=0.
// wO=1 while outFull=1 is a protocol violation; the slave drops the byte
// and records it in its sticky overflow flag. There is no backpressure on
// the strobe itself, so the master must sample outFull before asserting wO.
interface outbox_uart_tx_if;
  logic       wO;
  logic [7:0] i_data;
  logic       outFull;

  modport master (output wO, output i_data, input outFull);
  modport slave  (input wO, input i_data, output outFull);
endinterface

// File: rtl/outbox_fifo.sv
// outbox_fifo: synchronous FIFO with a write port and a pop port.
//   clk, i_rst : clock, synchronous active-low reset
//   i_wr       : write request; accepted only when not full
//   i_wdata    : data stored on an accepted write
//   i_pop      : pop request; ignored when empty
//   o_rdata    : head entry (valid while o_empty=0)
//   o_full     : count == DEPTH
//   o_empty    : count == 0
//   o_count    : registered occupancy
//   o_ovf      : sticky, set by a write while full; cleared only by reset
module outbox_fifo
  import hrm_io_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 8,
  localparam int AW   = clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic          o_ovf
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          wr_ok;
  logic          pop_ok;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_ovf   = ovf_q;
  assign o_rdata = mem_q[rptr_q];

  // Full is judged on the registered count, so a write arriving in the same
  // cycle as a pop from a full FIFO is still rejected.
  assign wr_ok  = i_wr && !o_full;
  assign pop_ok = i_pop && !o_empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q | (i_wr & o_full);
    // Pointers are AW bits wide and DEPTH is a power of 2, so +1 wraps.
    if (wr_ok)  wptr_d = wptr_q + 1'b1;
    if (pop_ok) rptr_d = rptr_q + 1'b1;
    case ({wr_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (i_rst && wr_ok) mem_q[wptr_q] <= i_wdata;
  end

endmodule

// File: rtl/outbox_uart_tx.sv
// outbox_uart_tx: OUTBOX consumer. Buffers bytes written by the control unit
// and sends each as an 8N1 UART frame (start 0, 8 data bits LSB first,
// stop 1) on tx.
//   clk, i_rst  : clock, synchronous active-low reset
//   ob (slave)  : wO / i_data / outFull write handshake
//   o_empty     : FIFO empty
//   o_ovf       : sticky overflow (write while full)
//   o_busy      : serializer not idle
//   tx          : serial line, idle high
//   o_dbg_state : serializer state (IDLE/START/DATA/STOP)
//   o_dbg_count : FIFO occupancy
module outbox_uart_tx
  import hrm_io_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int CLK_HZ       = 12000000,
  parameter int BAUD         = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
  input  logic                   clk,
  input  logic                   i_rst,
  outbox_uart_tx_if.slave        ob,
  output logic                   o_empty,
  output logic                   o_ovf,
  output logic                   o_busy,
  output logic                   tx,
  output logic [1:0]             o_dbg_state,
  output logic [clog2(DEPTH):0]  o_dbg_count
);

  localparam int            BW       = clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

  logic [7:0]    fifo_rdata;
  logic          fifo_empty;
  logic          pop;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          bit_done;

  outbox_fifo #(
    .DEPTH (DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (i_rst),
    .i_wr    (ob.wO),
    .i_wdata (ob.i_data),
    .i_pop   (pop),
    .o_rdata (fifo_rdata),
    .o_full  (ob.outFull),
    .o_empty (fifo_empty),
    .o_count (o_dbg_count),
    .o_ovf   (o_ovf)
  );

  assign o_empty     = fifo_empty;
  assign o_busy      = (state_q != IDLE);
  assign tx          = tx_q;
  assign o_dbg_state = state_q;
  assign bit_done    = (cnt_q == BIT_LAST);

  // tx_d is only changed on edges that enter a state or advance to the next
  // bit, so the registered line is glitch-free and aligned to bit periods.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_rdata;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // Drive the next bit straight from the pre-shift register so tx
            // and shreg step together on the same edge.
            shreg_d = shreg_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_outbox_uart_tx.sv
// tb_outbox_uart_tx: randomized and directed stimulus for outbox_uart_tx,
// checked every cycle against a frame-level reference model.
module tb_outbox_uart_tx;
  import hrm_io_pkg::*;

  localparam int DEPTH  = 4;
  localparam int CLK_HZ = 16;
  localparam int BAUD   = 4;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int FRAME  = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  outbox_uart_tx_if ob_if ();
  logic       o_empty, o_ovf, o_busy, tx;
  logic [1:0] dbg_state;
  logic [2:0] dbg_count;

  outbox_uart_tx #(
    .DEPTH  (DEPTH),
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk         (clk),
    .i_rst       (rst_n),
    .ob          (ob_if),
    .o_empty     (o_empty),
    .o_ovf       (o_ovf),
    .o_busy      (o_busy),
    .tx          (tx),
    .o_dbg_state (dbg_state),
    .o_dbg_count (dbg_count)
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds bytes accepted but not yet started on the line. A frame is
  // FRAME cycles of line time; m_left counts what is left of the current one.
  logic [7:0] exp_q[$];
  logic [7:0] m_byte;
  int         m_left;
  logic       m_ovf;
  int         n_cmp;
  int         n_err;
  logic       chk_en;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit do_pop;
    bit do_wr;
    if (!rst_n) begin
      exp_q.delete();
      m_left = 0;
      m_ovf  = 1'b0;
      m_byte = '0;
    end else begin
      do_pop = (m_left == 0) && (exp_q.size() > 0);
      do_wr  = ob_if.wO && (exp_q.size() < DEPTH);
      if (ob_if.wO && !do_wr) m_ovf = 1'b1;
      if (do_pop) begin
        m_byte = exp_q.pop_front();
        m_left = FRAME;
      end else if (m_left > 0) begin
        m_left--;
      end
      if (do_wr) exp_q.push_back(ob_if.i_data);
    end
  end

  function automatic int cur_slot();
    return (FRAME - m_left) / CPB;  // 0 start, 1..8 data, 9 stop
  endfunction

  function automatic logic exp_tx();
    int s;
    if (m_left == 0) return 1'b1;
    s = cur_slot();
    if (s == 0) return 1'b0;
    if (s <= 8) return m_byte[s-1];
    return 1'b1;
  endfunction

  function automatic logic [1:0] exp_state();
    int s;
    if (m_left == 0) return IDLE;
    s = cur_slot();
    if (s == 0) return START;
    if (s <= 8) return DATA;
    return STOP;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("tx",      32'(tx),        32'(exp_tx()));
      check_eq("busy",    32'(o_busy),    32'(m_left != 0));
      check_eq("state",   32'(dbg_state), 32'(exp_state()));
      check_eq("count",   32'(dbg_count), 32'(exp_q.size()));
      check_eq("outFull", 32'(ob_if.outFull), 32'(exp_q.size() == DEPTH));
      check_eq("empty",   32'(o_empty),   32'(exp_q.size() == 0));
      check_eq("ovf",     32'(o_ovf),     32'(m_ovf));
    end
  end

  // ---------------- driver tasks (entered and left at a negedge) ----------------
  task automatic write_byte(input logic [7:0] b);
    ob_if.i_data = b;
    ob_if.wO     = 1'b1;
    @(negedge clk);
    ob_if.wO     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_drained(input int limit);
    int n;
    n = 0;
    while ((m_left != 0 || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_timeout", 32'(n >= limit), 32'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    n_cmp        = 0;
    n_err        = 0;
    chk_en       = 1'b0;
    rst_n        = 1'b0;
    ob_if.wO     = 1'b0;
    ob_if.i_data = '0;

    // Reset held for three edges.
    @(posedge clk);
    chk_en = 1'b1;
    idle_cycles(3);
    check_eq("rst_tx",    32'(tx),            32'(1));
    check_eq("rst_empty", 32'(o_empty),       32'(1));
    check_eq("rst_full",  32'(ob_if.outFull), 32'(0));
    check_eq("rst_ovf",   32'(o_ovf),         32'(0));
    check_eq("rst_busy",  32'(o_busy),        32'(0));
    rst_n = 1'b1;
    idle_cycles(2);

    // Single byte.
    write_byte(8'hA5);
    wait_drained(200);
    idle_cycles(3);

    // Fill while busy, then overflow.
    write_byte(8'h5A);
    idle_cycles(2);
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    write_byte(8'h04);
    check_eq("fill_full", 32'(ob_if.outFull), 32'(1));
    write_byte(8'h05);
    check_eq("fill_ovf", 32'(o_ovf), 32'(1));
    wait_drained(400);

    // Write coinciding with the IDLE pop while two entries are held.
    write_byte(8'h77);
    idle_cycles(2);
    write_byte(8'h81);
    write_byte(8'h82);
    n = 0;
    while (!(m_left == 0 && exp_q.size() == 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("simul_timeout", 32'(n >= 100), 32'(0));
    write_byte(8'h83);
    check_eq("simul_count", 32'(dbg_count), 32'(2));
    write_byte(8'h84);
    write_byte(8'h85);
    check_eq("simul_full", 32'(ob_if.outFull), 32'(1));
    wait_drained(400);

    // Ten bytes through a four-entry FIFO, flow-controlled by outFull.
    for (int i = 0; i < 10; i++) begin
      n = 0;
      while (ob_if.outFull && n < 100) begin
        @(negedge clk);
        n++;
      end
      check_eq("wrap_timeout", 32'(n >= 100), 32'(0));
      write_byte(8'h10 + 8'(i));
    end
    wait_drained(600);

    // Random traffic, including writes while full.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) write_byte(8'($urandom_range(0, 255)));
      else @(negedge clk);
    end
    wait_drained(600);

    // Reset during data bit 3; the queued byte must not be sent afterwards.
    write_byte(8'h3C);
    write_byte(8'hC3);
    n = 0;
    while (m_left != FRAME - (4 * CPB + 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("mid_timeout", 32'(n >= 100), 32'(0));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_tx",    32'(tx),        32'(1));
    check_eq("mid_state", 32'(dbg_state), 32'(IDLE));
    check_eq("mid_empty", 32'(o_empty),   32'(1));
    check_eq("mid_ovf",   32'(o_ovf),     32'(0));
    idle_cycles(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
